wb_periph_slave: RTL and testbench



---
 rtl/wb_periph_pkg.sv | 35 +++
 rtl/wb_periph_slave_if.sv | 33 +++
 rtl/wb_periph_slave_cdt_timer.sv | 59 +++++
 rtl/wb_periph_slave.sv | 196 +++++++++++++++++++
 tb/tb_wb_periph_slave.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_periph_pkg.sv
// Shared definitions for the Wishbone peripheral slave: register map,
// bus FSM encoding and byte-lane merge helper.
package wb_periph_pkg;

    localparam logic [31:0] LED_OFS  = 32'h0000_0000;
    localparam logic [31:0] CDT_OFS  = 32'h0000_0010;
    localparam logic [31:0] STAT_OFS = 32'h0000_0014;

    localparam int STAT_EXPIRED_BIT = 0;

    // Wide enough for ACK_LATENCY-2 with ACK_LATENCY up to 15.
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_periph_slave_if.sv
// Wishbone B4 pipelined bus between the CPU bridge (master) and the
// peripheral register slave.
//
// Handshake: the master holds a request (stb with addr/we/data/sel) while
// cyc is high; the request is accepted on a rising edge where
// cyc & stb & !stall. Exactly one of ack/err answers each accepted request,
// for one cycle, and only while cyc stays high; dropping cyc abandons it.
interface wb_periph_slave_if;

    logic        m2s_cyc;
    logic        m2s_stb;
    logic        m2s_we;
    logic [31:0] m2s_addr;
    logic [31:0] m2s_data;
    logic [3:0]  m2s_sel;

    logic [31:0] s2m_data;
    logic        s2m_ack;
    logic        s2m_stall;
    logic        s2m_err;
    logic [31:0] s2m_err_addr;

    modport master (
        output m2s_cyc, m2s_stb, m2s_we, m2s_addr, m2s_data, m2s_sel,
        input  s2m_data, s2m_ack, s2m_stall, s2m_err, s2m_err_addr
    );

    modport slave (
        input  m2s_cyc, m2s_stb, m2s_we, m2s_addr, m2s_data, m2s_sel,
        output s2m_data, s2m_ack, s2m_stall, s2m_err, s2m_err_addr
    );

endinterface

// File: rtl/wb_periph_slave_cdt_timer.sv
// Prescaled countdown timer: decrements once per PRESCALE clocks, stops at
// zero and latches an expired flag on the 1->0 step.
module cdt_timer #(
    parameter int PRESCALE = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        clr,
    output logic [31:0] count,
    output logic        expired
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_INIT = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler;
    logic          tick;
    logic          dec;
    logic          expire_set;

    assign tick       = (prescaler == '0);
    // A bus load in the same cycle as a tick suppresses the decrement.
    assign dec        = tick & ~load & (count != '0);
    assign expire_set = dec & (count == 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= PRE_INIT;
        end else if (load || tick) begin
            prescaler <= PRE_INIT;
        end else begin
            prescaler <= prescaler - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 32'd1;
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expired <= 1'b0;
        end else if (expire_set) begin
            expired <= 1'b1;
        end else if (clr) begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_periph_slave.sv
// Wishbone B4 pipelined register slave holding the LED register and the
// countdown timer; one outstanding transaction, fixed response latency.
module wb_periph_slave
    import wb_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          ACK_LATENCY  = 1,
    parameter int          CDT_PRESCALE = 27
) (
    input  logic             clk,
    input  logic             i_resetn,
    wb_periph_slave_if.slave bus,
    output logic [5:0]       o_leds,
    output logic             o_cdt_irq,
    output wb_state_t        dbg_state
);

    localparam logic [LAT_W-1:0] LAT_INIT =
        (ACK_LATENCY > 1) ? LAT_W'(ACK_LATENCY - 2) : '0;

    localparam logic [31:0] LED_ADDR  = BASE_ADDR + LED_OFS;
    localparam logic [31:0] CDT_ADDR  = BASE_ADDR + CDT_OFS;
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + STAT_OFS;

    wb_state_t        state;
    wb_state_t        next_state;
    logic [LAT_W-1:0] lat_cnt;

    logic        hit_led;
    logic        hit_cdt;
    logic        hit_stat;
    logic        hit_any;
    logic        accept;

    logic [31:0] led_reg;
    logic [31:0] cdt_count;
    logic        cdt_expired;
    logic        cdt_load;
    logic [31:0] cdt_load_val;
    logic        stat_clr;

    logic [31:0] rd_val;
    logic [31:0] acc_rdata;
    logic [31:0] pend_rdata;
    logic        pend_err;

    logic        resp_go;
    logic        resp_err;
    logic        ack_d;
    logic        err_d;
    logic [31:0] data_d;
    logic        stall_d;

    logic        ack_q;
    logic        err_q;
    logic [31:0] data_q;
    logic [31:0] err_addr_q;

    // Word-granular decode: byte offset bits are ignored.
    assign hit_led  = (bus.m2s_addr[31:2] == LED_ADDR[31:2]);
    assign hit_cdt  = (bus.m2s_addr[31:2] == CDT_ADDR[31:2]);
    assign hit_stat = (bus.m2s_addr[31:2] == STAT_ADDR[31:2]);
    assign hit_any  = hit_led | hit_cdt | hit_stat;

    assign accept = bus.m2s_cyc & bus.m2s_stb & (state == ST_IDLE);

    assign cdt_load     = accept & bus.m2s_we & hit_cdt & (|bus.m2s_sel);
    assign cdt_load_val = merge_bytes(cdt_count, bus.m2s_data, bus.m2s_sel);
    assign stat_clr     = accept & bus.m2s_we & hit_stat
                        & bus.m2s_sel[STAT_EXPIRED_BIT / 8]
                        & bus.m2s_data[STAT_EXPIRED_BIT];

    cdt_timer #(
        .PRESCALE (CDT_PRESCALE)
    ) u_cdt (
        .clk      (clk),
        .rst_n    (i_resetn),
        .load     (cdt_load),
        .load_val (cdt_load_val),
        .clr      (stat_clr),
        .count    (cdt_count),
        .expired  (cdt_expired)
    );

    always_comb begin
        rd_val = '0;
        if (hit_led) begin
            rd_val = led_reg;
        end else if (hit_cdt) begin
            rd_val = cdt_count;
        end else if (hit_stat) begin
            rd_val[STAT_EXPIRED_BIT] = cdt_expired;
        end
    end

    assign acc_rdata = bus.m2s_we ? '0 : rd_val;

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            led_reg <= '0;
        end else if (accept && bus.m2s_we && hit_led) begin
            led_reg <= merge_bytes(led_reg, bus.m2s_data, bus.m2s_sel);
        end
    end

    // Request context held across WAIT so the response reflects the
    // register value seen at acceptance.
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            pend_err   <= 1'b0;
            pend_rdata <= '0;
            err_addr_q <= '0;
        end else if (accept) begin
            pend_err   <= ~hit_any;
            pend_rdata <= acc_rdata;
            if (!hit_any) begin
                err_addr_q <= bus.m2s_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            lat_cnt <= '0;
        end else if (accept) begin
            lat_cnt <= LAT_INIT;
        end else if (state == ST_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (ACK_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.m2s_cyc) begin
                    next_state = ST_IDLE;
                end else if (lat_cnt == '0) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Response flags are computed for the edge that enters RESP and then
    // registered, so ack/err line up with the RESP cycle.
    always_comb begin
        resp_go  = (next_state == ST_RESP);
        resp_err = (state == ST_IDLE) ? ~hit_any : pend_err;
        ack_d    = resp_go & ~resp_err;
        err_d    = resp_go & resp_err;
        data_d   = '0;
        if (ack_d) begin
            data_d = (state == ST_IDLE) ? acc_rdata : pend_rdata;
        end
        stall_d  = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q  <= ack_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    assign bus.s2m_ack      = ack_q;
    assign bus.s2m_err      = err_q;
    assign bus.s2m_data     = data_q;
    assign bus.s2m_stall    = stall_d;
    assign bus.s2m_err_addr = err_addr_q;

    assign o_leds    = ~led_reg[5:0];
    assign o_cdt_irq = cdt_expired;
    assign dbg_state = state;

endmodule

// File: tb/tb_wb_periph_slave.sv
// Bench for wb_periph_slave: two instances (latency 1 and 3), directed
// transactions with expected responses queued and checked by a monitor.
module tb_wb_periph_slave;
  import wb_periph_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  time acc_time;

  // {check_data, err, data}
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  logic [1:0]  m_cyc, m_stb, m_we;
  logic [31:0] m_addr[2];
  logic [31:0] m_data[2];
  logic [3:0]  m_sel[2];

  logic [1:0]  r_ack, r_err, r_stall;
  logic [31:0] r_data[2];
  logic [31:0] r_eaddr[2];

  logic [5:0]  leds_a, leds_b;
  logic        irq_a, irq_b;
  wb_state_t   st_a, st_b;

  wb_periph_slave_if bus_a ();
  wb_periph_slave_if bus_b ();

  assign bus_a.m2s_cyc  = m_cyc[0];
  assign bus_a.m2s_stb  = m_stb[0];
  assign bus_a.m2s_we   = m_we[0];
  assign bus_a.m2s_addr = m_addr[0];
  assign bus_a.m2s_data = m_data[0];
  assign bus_a.m2s_sel  = m_sel[0];
  assign bus_b.m2s_cyc  = m_cyc[1];
  assign bus_b.m2s_stb  = m_stb[1];
  assign bus_b.m2s_we   = m_we[1];
  assign bus_b.m2s_addr = m_addr[1];
  assign bus_b.m2s_data = m_data[1];
  assign bus_b.m2s_sel  = m_sel[1];

  assign r_ack[0]   = bus_a.s2m_ack;
  assign r_err[0]   = bus_a.s2m_err;
  assign r_stall[0] = bus_a.s2m_stall;
  assign r_data[0]  = bus_a.s2m_data;
  assign r_eaddr[0] = bus_a.s2m_err_addr;
  assign r_ack[1]   = bus_b.s2m_ack;
  assign r_err[1]   = bus_b.s2m_err;
  assign r_stall[1] = bus_b.s2m_stall;
  assign r_data[1]  = bus_b.s2m_data;
  assign r_eaddr[1] = bus_b.s2m_err_addr;

  wb_periph_slave #(.BASE_ADDR(BASE), .ACK_LATENCY(1), .CDT_PRESCALE(4)) dut_a (
    .clk(clk), .i_resetn(rst_n), .bus(bus_a),
    .o_leds(leds_a), .o_cdt_irq(irq_a), .dbg_state(st_a)
  );

  wb_periph_slave #(.BASE_ADDR(BASE), .ACK_LATENCY(3), .CDT_PRESCALE(4)) dut_b (
    .clk(clk), .i_resetn(rst_n), .bus(bus_b),
    .o_leds(leds_b), .o_cdt_irq(irq_b), .dbg_state(st_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon_one(input int b, input logic ack, input logic err, input logic [31:0] data);
    logic [33:0] e;
    int n;
    if (ack || err) begin
      chk("ack_err_exclusive", {31'b0, ack & err}, 32'd0);
      chk("resp_in_live_cycle", {31'b0, m_cyc[b]}, 32'd1);
      n = (b == 0) ? exp_q0.size() : exp_q1.size();
      if (n == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp bus%0d: got ack=%0b err=%0b, required no response", b, ack, err);
      end else begin
        if (b == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk("resp_is_err", {31'b0, err}, {31'b0, e[32]});
        if (e[33]) chk("resp_data", data, e[31:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_one(0, r_ack[0], r_err[0], r_data[0]);
      mon_one(1, r_ack[1], r_err[1], r_data[1]);
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge showing the response.
  task automatic xfer(input int b, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel,
                      input logic exp_err, input logic [31:0] exp_data,
                      input logic chk_data, input int lat);
    int n;
    if (b == 0) exp_q0.push_back({chk_data, exp_err, exp_data});
    else        exp_q1.push_back({chk_data, exp_err, exp_data});
    m_cyc[b] = 1'b1;
    m_stb[b] = 1'b1;
    m_we[b] = we;
    m_addr[b] = addr;
    m_data[b] = wdata;
    m_sel[b] = sel;
    n = 0;
    while (r_stall[b] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout bus%0d: stall still 1 after 50 cycles, required 0", b);
      m_stb[b] = 1'b0;
      if (b == 0) void'(exp_q0.pop_back());
      else        void'(exp_q1.pop_back());
      return;
    end
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    m_stb[b] = 1'b0;
    n = 1;
    while (!(r_ack[b] || r_err[b]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_latency", n, lat);
  endtask

  task automatic wr(input int b, input logic [31:0] addr, input logic [31:0] d, input logic [3:0] sel, input int lat);
    xfer(b, 1'b1, addr, d, sel, 1'b0, 32'd0, 1'b0, lat);
  endtask

  task automatic rd(input int b, input logic [31:0] addr, input logic [31:0] exp, input int lat);
    xfer(b, 1'b0, addr, 32'd0, 4'hF, 1'b0, exp, 1'b1, lat);
  endtask

  task automatic rd_err(input int b, input logic [31:0] addr, input int lat);
    xfer(b, 1'b0, addr, 32'd0, 4'hF, 1'b1, 32'd0, 1'b1, lat);
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] exp_stall_pat;
  logic [8:0] exp_ack_pat;
  time t0;
  int  n_wait;

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int b = 0; b < 2; b++) begin
      m_addr[b] = '0; m_data[b] = '0; m_sel[b] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ack",      {31'b0, r_ack[0]},   32'd0);
    chk("rst_err",      {31'b0, r_err[0]},   32'd0);
    chk("rst_stall",    {31'b0, r_stall[0]}, 32'd0);
    chk("rst_data",     r_data[0],           32'd0);
    chk("rst_err_addr", r_eaddr[0],          32'd0);
    chk("rst_leds",     {26'b0, leds_a},     32'h3F);
    chk("rst_irq",      {31'b0, irq_a},      32'd0);
    chk("rst_state",    {30'b0, st_a},       {30'b0, ST_IDLE});
    chk("rst_stall_b",  {31'b0, r_stall[1]}, 32'd0);
    chk("rst_leds_b",   {26'b0, leds_b},     32'h3F);

    m_cyc = 2'b11;

    // LED write / readback
    wr(0, BASE, 32'h0000_0015, 4'hF, 1);
    chk("leds_after_0x15", {26'b0, leds_a}, 32'h2A);
    rd(0, BASE, 32'h0000_0015, 1);

    // Byte lanes, sel=0, ignored low address bits
    wr(0, BASE, 32'h1122_3344, 4'hF, 1);
    wr(0, BASE, 32'hAABB_CCDD, 4'b0101, 1);
    rd(0, BASE, 32'h11BB_33DD, 1);
    wr(0, BASE, 32'hFFFF_FFFF, 4'b0000, 1);
    rd(0, BASE + 32'h3, 32'h11BB_33DD, 1);
    chk("leds_after_lanes", {26'b0, leds_a}, 32'h22);

    // Unmapped addresses
    rd_err(0, BASE + 32'h8, 1);
    chk("err_addr_base8", r_eaddr[0], BASE + 32'h8);
    rd_err(0, 32'h0000_1000, 1);
    chk("err_addr_1000", r_eaddr[0], 32'h0000_1000);
    xfer(0, 1'b1, BASE + 32'hC, 32'h0000_0000, 4'hF, 1'b1, 32'd0, 1'b0, 1);
    chk("err_addr_write", r_eaddr[0], BASE + 32'hC);
    rd(0, BASE, 32'h11BB_33DD, 1);
    rd(0, BASE + 32'h14, 32'd0, 1);

    // CDT countdown with prescale 4
    wr(0, BASE + 32'h10, 32'd3, 4'hF, 1);
    t0 = acc_time;
    rd(0, BASE + 32'h10, 32'd3, 1);
    n_wait = 0;
    while (!irq_a && n_wait < 100) begin
      @(negedge clk);
      n_wait++;
    end
    chk("cdt_expiry_cycles", 32'(($time - t0 - 5) / 10), 32'd12);
    repeat (8) @(negedge clk);
    rd(0, BASE + 32'h10, 32'd0, 1);
    rd(0, BASE + 32'h14, 32'd1, 1);
    wr(0, BASE + 32'h14, 32'd1, 4'hF, 1);
    chk("irq_after_w1c", {31'b0, irq_a}, 32'd0);
    rd(0, BASE + 32'h14, 32'd0, 1);
    wr(0, BASE + 32'h10, 32'd0, 4'hF, 1);
    repeat (10) @(negedge clk);
    chk("irq_after_cdt0", {31'b0, irq_a}, 32'd0);
    rd(0, BASE + 32'h14, 32'd0, 1);

    // Latency 3 and back-to-back strobes
    wr(1, BASE, 32'h0000_00A5, 4'hF, 3);
    rd(1, BASE, 32'h0000_00A5, 3);
    @(negedge clk);
    exp_stall_pat = 9'b0_1110_1110;
    exp_ack_pat   = 9'b0_1000_1000;
    exp_q1.push_back({1'b1, 1'b0, 32'h0000_00A5});
    exp_q1.push_back({1'b1, 1'b0, 32'h0000_00A5});
    m_we[1] = 1'b0; m_addr[1] = BASE; m_sel[1] = 4'hF; m_stb[1] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_stall_%0d", i), {31'b0, r_stall[1]}, {31'b0, exp_stall_pat[i]});
      chk($sformatf("b2b_ack_%0d", i), {31'b0, r_ack[1]}, {31'b0, exp_ack_pat[i]});
    end
    m_stb[1] = 1'b0;

    // Abort: write committed, cyc dropped in WAIT, no response
    m_we[1] = 1'b1; m_addr[1] = BASE; m_data[1] = 32'h0000_003C; m_sel[1] = 4'hF; m_stb[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_wait", {30'b0, st_b}, {30'b0, ST_WAIT});
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    @(negedge clk);
    chk("abort_state_idle", {30'b0, st_b}, {30'b0, ST_IDLE});
    chk("abort_stall_low", {31'b0, r_stall[1]}, 32'd0);
    repeat (4) @(negedge clk);
    m_cyc[1] = 1'b1;
    rd(1, BASE, 32'h0000_003C, 3);

    // Asynchronous reset mid-countdown with a pending read on bus B
    wr(0, BASE + 32'h10, 32'h0000_0100, 4'hF, 1);
    @(negedge clk);
    m_we[1] = 1'b0; m_addr[1] = BASE; m_sel[1] = 4'hF; m_stb[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_stb[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_leds_a",     {26'b0, leds_a},     32'h3F);
    chk("arst_leds_b",     {26'b0, leds_b},     32'h3F);
    chk("arst_err_addr_a", r_eaddr[0],          32'd0);
    chk("arst_ack_b",      {31'b0, r_ack[1]},   32'd0);
    chk("arst_stall_b",    {31'b0, r_stall[1]}, 32'd0);
    chk("arst_state_b",    {30'b0, st_b},       {30'b0, ST_IDLE});
    chk("arst_irq_a",      {31'b0, irq_a},      32'd0);
    chk("arst_data_a",     r_data[0],           32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rd(0, BASE + 32'h10, 32'd0, 1);
    rd(0, BASE, 32'd0, 1);
    rd(1, BASE, 32'd0, 3);

    repeat (3) @(negedge clk);
    chk("exp_q_a_drained", exp_q0.size(), 32'd0);
    chk("exp_q_b_drained", exp_q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
